seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the 2-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, with early termination on the first differing digit.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Start/busy/done handshake; registered result flags held until the next result. Sits on the datapath wherever the wide comparisons are not timing-critical.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- DIGIT, 2, bits examined per cycle; WIDTH % DIGIT must be 0 (checked at elaboration, fatal otherwise).
- NDIG, WIDTH/DIGIT, derived (localparam), number of digits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  high in COMPARE.
- done  out  1  one-cycle pulse; result flags valid from this cycle.
- A_greater  out  1  A > B (registered).
- A_less  out  1  A < B (registered).
- A_equal  out  1  A == B (registered).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, A_greater, A_less and A_equal all 0; digit counter 0.
- Reset has priority over everything. Reset mid-COMPARE aborts the operation, and no done is produced.
- FSM states: IDLE, COMPARE, DONE.
- IDLE -> COMPARE on start=1:
  - Latch A and B into shift registers, and latch signed_mode.
  - When signed_mode=1, invert the MSB of both latched copies, so that an unsigned compare yields the signed ordering.
  - Counter = 0.
- COMPARE, each cycle: take the top DIGIT bits of each shift register.
  - Digits differ: record greater or less from the unsigned digit comparison, then go to DONE.
  - Digits equal and counter == NDIG-1: record equal, then go to DONE.
  - Otherwise: shift both registers left by DIGIT, increment counter, stay in COMPARE.
- DONE: lasts exactly one cycle, with done=1 and flags updated on entry. Then go to IDLE.
- Timing: start sampled at edge T. COMPARE occupies cycles T+1..T+k, where k is the 1-based index of the first differing digit, or NDIG if the operands are equal. done is high in cycle T+k+1.
- Latency: min 2 cycles start->done; max NDIG+1 cycles.
- Flags:
  - Exactly one flag is high after the first completed operation.
  - Flags are unchanged during COMPARE (they still show the previous result) and change only on DONE entry.
  - All flags are 0 from reset until the first done.
- start while busy or in DONE is ignored; no queueing. A new start is accepted in the first IDLE cycle after DONE (back-to-back spacing is k+2 cycles).
- Changes to A, B or signed_mode after acceptance have no effect on the operation in flight.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, DIGIT=2. After reset, hold: busy=0, done=0, flags=000 for 5 cycles with start=0.
- Unsigned, A=0xA5, B=0x25, start at T -> first digit differs; done at T+2; A_greater=1, others 0; busy high only in T+1.
- Signed, A=0xA5 (-91), B=0x25 (37) -> done at T+2; A_less=1. Same operands unsigned -> A_greater=1.
- Equal, A=B=0x3C, both modes -> done at T+5; A_equal=1. Then A=0x01, B=0x02 unsigned -> done at T+5, A_less=1.
- Start re-asserted with new operands during COMPARE and during DONE -> ignored; the result matches the first operation. Next start accepted in the following IDLE cycle.
- rst_n pulsed low mid-COMPARE -> outputs immediately 0 (asynchronous); no done pulse. A subsequent operation completes correctly.

Source files
------------

// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand bus for the sequential magnitude comparator.
// The master issues operations; the slave (the comparator) returns status and result flags.
interface seq_mag_comparator_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_greater;
    logic             A_less;
    logic             A_equal;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_greater, A_less, A_equal
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_greater, A_less, A_equal
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit.
// Signed mode flips both operand MSBs at capture so the unsigned digit compare gives signed order.
module seq_mag_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_mag_comparator_if.slave bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $fatal(1, "seq_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             greater;
    logic             less;
    logic             equal;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             last;

    assign dig_a = sh_a[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b[WIDTH-1 -: DIGIT];
    assign last  = (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = COMPARE;
            COMPARE: if ((dig_a != dig_b) || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flags load only on the edge that enters DONE, so they hold the previous result while comparing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            greater <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a <= bus.A ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                        sh_b <= bus.B ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                        cnt  <= '0;
                    end
                end
                COMPARE: begin
                    if (dig_a > dig_b) begin
                        {greater, less, equal} <= 3'b100;
                    end else if (dig_a < dig_b) begin
                        {greater, less, equal} <= 3'b010;
                    end else if (last) begin
                        {greater, less, equal} <= 3'b001;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == COMPARE);
    assign bus.done      = (state == DONE);
    assign bus.A_greater = greater;
    assign bus.A_less    = less;
    assign bus.A_equal   = equal;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed-vector bench for seq_mag_comparator (WIDTH=8, DIGIT=2) with hand-computed results.
module tb_seq_mag_comparator;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [2:0]  prev_flags;

    always #5 clk = ~clk;

    seq_mag_comparator_if #(.WIDTH(8)) bus ();

    seq_mag_comparator #(
        .WIDTH(8),
        .DIGIT(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [2:0] flags();
        return {bus.A_greater, bus.A_less, bus.A_equal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one operation, then check busy for k cycles, the done cycle and the following idle cycle.
    task automatic run_op(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input int unsigned k, input logic [2:0] exp_flags);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.A           = a;
        bus.B           = b;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.A           = ~a;
        bus.B           = ~b;
        bus.signed_mode = ~sm;
        for (int unsigned i = 0; i < k; i++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " done early"}, 32'(bus.done), 32'd0);
            check({tag, " flags held"}, 32'(flags()), 32'(prev_flags));
        end
        @(negedge clk);
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy in done"}, 32'(bus.busy), 32'd0);
        check({tag, " flags"}, 32'(flags()), 32'(exp_flags));
        prev_flags = exp_flags;
        @(negedge clk);
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
        check({tag, " flags kept"}, 32'(flags()), 32'(exp_flags));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        prev_flags      = 3'b000;
        #1;
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset flags", 32'(flags()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle busy", 32'(bus.busy), 32'd0);
            check("idle done", 32'(bus.done), 32'd0);
            check("idle flags", 32'(flags()), 32'd0);
        end

        run_op("u A5>25",       1'b0, 8'hA5, 8'h25, 1, 3'b100);
        run_op("s A5<25",       1'b1, 8'hA5, 8'h25, 1, 3'b010);
        run_op("u A5>25 again", 1'b0, 8'hA5, 8'h25, 1, 3'b100);
        run_op("u 3C==3C",      1'b0, 8'h3C, 8'h3C, 4, 3'b001);
        run_op("s 3C==3C",      1'b1, 8'h3C, 8'h3C, 4, 3'b001);
        run_op("u 01<02",       1'b0, 8'h01, 8'h02, 4, 3'b010);
        run_op("s FE<FF",       1'b1, 8'hFE, 8'hFF, 4, 3'b010);
        run_op("u 30>20",       1'b0, 8'h30, 8'h20, 2, 3'b100);
        run_op("u 40<80",       1'b0, 8'h40, 8'h80, 1, 3'b010);
        run_op("s 7F>80",       1'b1, 8'h7F, 8'h80, 1, 3'b100);

        // start held high with new operands through COMPARE and DONE
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.A           = 8'h01;
        bus.B           = 8'h02;
        @(posedge clk);
        #1;
        bus.A = 8'hFF;
        bus.B = 8'h00;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ign busy", 32'(bus.busy), 32'd1);
            check("ign done early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        check("ign done", 32'(bus.done), 32'd1);
        check("ign flags", 32'(flags()), 32'(3'b010));
        @(negedge clk);
        check("ign idle busy", 32'(bus.busy), 32'd0);
        check("ign idle done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("next accepted busy", 32'(bus.busy), 32'd1);
        check("next flags held", 32'(flags()), 32'(3'b010));
        bus.start = 1'b0;
        @(negedge clk);
        check("next done", 32'(bus.done), 32'd1);
        check("next flags", 32'(flags()), 32'(3'b100));
        prev_flags = 3'b100;
        @(negedge clk);
        check("next done pulse", 32'(bus.done), 32'd0);

        // reset asserted in the middle of a 4-digit compare
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h01;
        bus.B     = 8'h02;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("pre-reset busy", 32'(bus.busy), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset flags", 32'(flags()), 32'd0);
        prev_flags = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post reset done", 32'(bus.done), 32'd0);
            check("post reset busy", 32'(bus.busy), 32'd0);
        end
        run_op("s 80<7F after reset", 1'b1, 8'h80, 8'h7F, 1, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
